// File: rtl/input_port_ctrl_pkg.sv
// Shared types and defaults for the processor input port.
// Holds the FSM state encoding and default sizing constants.
package input_port_ctrl_pkg;

  localparam int DEF_DATA_W          = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    VALID    = 2'd2
  } state_t;

endpackage

// File: rtl/input_port_ctrl_key_debounce.sv
// Key synchronizer, debouncer and rising-edge pulse generator.
// A level change is accepted after DEBOUNCE_CYCLES differing samples.
module key_debounce
  import input_port_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clkIn,
  input  logic reset,
  input  logic key_raw,
  output logic key_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_key_db;
  logic          r_key_db_d;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing samples; accept the new level on the last one.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_key_db <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_key_db) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_key_db <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) r_key_db_d <= 1'b0;
    else       r_key_db_d <= r_key_db;
  end

  assign key_pulse = r_key_db & ~r_key_db_d;

endmodule

// File: rtl/input_port_ctrl.sv
// Processor IN-instruction port: waits for a debounced key press
// and hands the synchronized switch word to the processor.
module input_port_ctrl
  import input_port_ctrl_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clkIn,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_raw,
  input  logic              key_raw,
  input  logic              in_req,
  input  logic              in_ack,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              waiting,
  output logic              key_pulse
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_sw_s1;
  logic [DATA_W-1:0] r_sw_s2;
  logic [DATA_W-1:0] r_data;
  logic              w_key_pulse;
  logic              w_capture;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clkIn    (clkIn),
    .reset    (reset),
    .key_raw  (key_raw),
    .key_pulse(w_key_pulse)
  );

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw_raw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // State register.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; presses outside WAIT_KEY are dropped, not buffered.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_req) w_next = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (w_key_pulse)  w_next = VALID;
        else if (!in_req) w_next = IDLE;
      end
      VALID: begin
        if (in_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_capture = (r_state == WAIT_KEY) && w_key_pulse;

  // Capture the switch word on the accepted press; hold it otherwise.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset)          r_data <= '0;
    else if (w_capture) r_data <= r_sw_s2;
  end

  assign in_data   = r_data;
  assign in_valid  = (r_state == VALID);
  assign waiting   = (r_state == WAIT_KEY);
  assign key_pulse = w_key_pulse;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl with a short debounce window.
// Expected values are hand-computed constants.
module tb_input_port_ctrl;

  localparam int DW = 16;
  localparam int DB = 4;

  logic          clkIn = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sw_raw = '0;
  logic          key_raw = 1'b0;
  logic          in_req = 1'b0;
  logic          in_ack = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          waiting;
  logic          key_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int c0 = 0;

  input_port_ctrl #(
    .DATA_W(DW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clkIn    (clkIn),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .key_raw  (key_raw),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .in_valid (in_valid),
    .waiting  (waiting),
    .key_pulse(key_pulse)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) cyc++;

  always @(negedge clkIn) begin
    if (key_pulse) begin
      pulse_cnt++;
      pulse_cyc = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clkIn);
      #1;
    end
  endtask

  initial begin
    tick(2);
    chk("rst_valid", 32'(in_valid), 32'd0);
    chk("rst_data", 32'(in_data), 32'd0);
    chk("rst_wait", 32'(waiting), 32'd0);
    chk("rst_pulse", 32'(key_pulse), 32'd0);
    reset = 1'b0;
    tick(1);

    // Abort
    in_req = 1'b1;
    tick(1);
    chk("abort_wait1", 32'(waiting), 32'd1);
    in_req = 1'b0;
    tick(1);
    chk("abort_wait0", 32'(waiting), 32'd0);
    chk("abort_valid", 32'(in_valid), 32'd0);
    chk("abort_data", 32'(in_data), 32'd0);

    // Basic
    sw_raw = 16'hBEEF;
    in_req = 1'b1;
    tick(1);
    chk("basic_wait", 32'(waiting), 32'd1);
    pulse_cnt = 0;
    key_raw = 1'b1;
    tick(10);
    chk("basic_pulses", 32'(pulse_cnt), 32'd1);
    chk("basic_valid", 32'(in_valid), 32'd1);
    chk("basic_data", 32'(in_data), 32'hBEEF);
    chk("basic_wait0", 32'(waiting), 32'd0);
    in_ack = 1'b1;
    in_req = 1'b0;
    key_raw = 1'b0;
    tick(1);
    chk("basic_ack", 32'(in_valid), 32'd0);
    in_ack = 1'b0;
    tick(8);

    // Bounce
    sw_raw = 16'h5A5A;
    in_req = 1'b1;
    tick(1);
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      key_raw = (i % 2 == 0);
      tick(2);
    end
    chk("bounce_none", 32'(pulse_cnt), 32'd0);
    key_raw = 1'b1;
    c0 = cyc;
    tick(10);
    chk("bounce_pulses", 32'(pulse_cnt), 32'd1);
    chk("bounce_lat", 32'(pulse_cyc - c0), 32'd6);
    chk("bounce_data", 32'(in_data), 32'h5A5A);
    in_ack = 1'b1;
    in_req = 1'b0;
    key_raw = 1'b0;
    tick(1);
    in_ack = 1'b0;
    tick(8);

    // Ordering
    sw_raw = 16'h1111;
    key_raw = 1'b1;
    tick(8);
    in_req = 1'b1;
    tick(4);
    chk("order_novalid", 32'(in_valid), 32'd0);
    chk("order_wait", 32'(waiting), 32'd1);
    key_raw = 1'b0;
    tick(8);
    sw_raw = 16'h2222;
    tick(2);
    key_raw = 1'b1;
    tick(10);
    chk("order_valid", 32'(in_valid), 32'd1);
    chk("order_data", 32'(in_data), 32'h2222);
    in_ack = 1'b1;
    in_req = 1'b0;
    key_raw = 1'b0;
    tick(1);
    in_ack = 1'b0;
    tick(8);

    // Hold
    sw_raw = 16'h1234;
    in_req = 1'b1;
    tick(3);
    key_raw = 1'b1;
    tick(10);
    chk("hold_data0", 32'(in_data), 32'h1234);
    sw_raw = 16'hFFFF;
    key_raw = 1'b0;
    tick(8);
    key_raw = 1'b1;
    tick(10);
    in_req = 1'b0;
    tick(2);
    chk("hold_data", 32'(in_data), 32'h1234);
    chk("hold_valid", 32'(in_valid), 32'd1);
    in_ack = 1'b1;
    tick(1);
    in_ack = 1'b0;
    chk("hold_ackv", 32'(in_valid), 32'd0);
    chk("hold_keep", 32'(in_data), 32'h1234);
    key_raw = 1'b0;
    tick(8);

    // Re-request after ack, then reset in VALID
    sw_raw = 16'hABCD;
    in_req = 1'b1;
    tick(3);
    key_raw = 1'b1;
    tick(10);
    chk("rereq_data", 32'(in_data), 32'hABCD);
    in_ack = 1'b1;
    tick(1);
    in_ack = 1'b0;
    chk("rereq_idle", 32'(waiting), 32'd0);
    tick(1);
    chk("rereq_wait", 32'(waiting), 32'd1);
    key_raw = 1'b0;
    tick(8);
    sw_raw = 16'h4321;
    tick(2);
    key_raw = 1'b1;
    tick(10);
    chk("mid_valid", 32'(in_valid), 32'd1);
    chk("mid_data", 32'(in_data), 32'h4321);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(in_valid), 32'd0);
    chk("async_data", 32'(in_data), 32'd0);
    chk("async_wait", 32'(waiting), 32'd0);
    chk("async_pulse", 32'(key_pulse), 32'd0);
    tick(1);
    reset = 1'b0;
    in_req = 1'b0;
    key_raw = 1'b0;
    tick(2);
    chk("post_wait", 32'(waiting), 32'd0);
    chk("post_valid", 32'(in_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: width of the switch data word delivered to the processor.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-level cycles required to accept a key change (20 ms at 50 MHz).
REQ-003 clkIn  input  1: single clock for all logic, rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 sw_raw  input  DATA_W: unsynchronized board switches.
REQ-006 key_raw  input  1: unsynchronized confirm button, already active-high (pressed = 1).
REQ-007 in_req  input  1: processor IN instruction requesting a data word, level.
REQ-008 in_ack  input  1: processor has consumed in_data, one-cycle pulse or level.
REQ-009 in_data  output  DATA_W: registered data word, stable while in_valid = 1.
REQ-010 in_valid  output  1: in_data holds the captured word.
REQ-011 waiting  output  1: high in WAIT_KEY; drives an LED prompting the user.
REQ-012 key_pulse  output  1: one-cycle pulse on each debounced key press.

Function
REQ-013 key_raw and sw_raw SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 The debouncer SHALL hold key_db and a counter of width $clog2(DEBOUNCE_CYCLES+1).
- Counter clears whenever the synchronized key equals key_db.
- Counter increments while the synchronized key differs from key_db.
- At count DEBOUNCE_CYCLES-1 with the level still differing, key_db takes the new level and the counter clears.
- Net effect: a change is accepted after exactly DEBOUNCE_CYCLES consecutive differing samples.
REQ-015 key_pulse SHALL assert for exactly one cycle, in the cycle after key_db rises 0->1; a falling key_db produces no pulse.
REQ-016 The FSM SHALL have states IDLE, WAIT_KEY, VALID.
REQ-017 IDLE -> WAIT_KEY when in_req = 1; a key_pulse coincident with or before this transition SHALL be ignored, with no buffering of presses.
REQ-018 WAIT_KEY -> VALID on key_pulse.
- in_data captures the synchronized switch word in that same cycle.
- in_valid = 1 from the next cycle (latency 1 from key_pulse).
REQ-019 WAIT_KEY -> IDLE if in_req drops before key_pulse (abort); in_data is left unchanged.
REQ-020 VALID -> IDLE on in_ack = 1.
- in_valid drops the next cycle.
- in_data keeps its value until the next capture.
REQ-021 In VALID, in_req deasserting SHALL NOT drop in_valid; only in_ack or reset leaves VALID.
REQ-022 A further key_pulse while in VALID SHALL be ignored and SHALL NOT change in_data.
REQ-023 in_ack outside VALID SHALL be ignored.
REQ-024 After VALID->IDLE, a still-high in_req SHALL start a new request, entering WAIT_KEY one cycle later.
REQ-025 waiting = 1 iff the state is WAIT_KEY; in_valid = 1 iff the state is VALID; both are registered or decoded directly from state, with no combinational path from inputs.

Reset
REQ-026 On reset = 1, asynchronously:
- state = IDLE;
- in_data = 0, in_valid = 0, waiting = 0, key_pulse = 0;
- key_db = 0, debounce counter = 0;
- all synchronizer flops = 0.
REQ-027 A reset asserted mid-debounce or in VALID SHALL discard the pending press or word; operation resumes from IDLE on the first clock after release.

Structure
REQ-028 A shared package SHALL hold the FSM state enum typedef (IDLE, WAIT_KEY, VALID) and the default DATA_W and DEBOUNCE_CYCLES constants.
REQ-029 Synchronizer, debounce counter and edge detect SHALL be one sub-module, key_debounce, instantiated once; the FSM and data capture live in input_port_ctrl.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-030 Basic: in_req=1, sw_raw=16'hBEEF, key held high 10 cycles -> key_pulse once; in_valid=1 with in_data=16'hBEEF; in_ack pulse -> in_valid=0 the next cycle.
REQ-031 Bounce: key toggled every 2 cycles for 12 cycles, then held high -> exactly one key_pulse, 4+2 cycles after the last toggle (debounce plus synchronizer).
REQ-032 Ordering: key pressed in IDLE, then in_req=1 -> no capture; in_valid=1 only after release and a new press, with in_data equal to the switches sampled at the second press.
REQ-033 Abort: in_req=1, then in_req=0 before the press -> state IDLE, waiting=0, in_data unchanged (0 after reset).
REQ-034 Hold: in VALID with in_data=16'h1234, sw_raw changed to 16'hFFFF, second press, in_req dropped -> in_data stays 16'h1234 and in_valid stays 1 until in_ack.
REQ-035 Reset mid-operation: reset asserted in VALID -> in_valid, in_data, waiting and key_pulse all 0 immediately, without waiting for a clock edge.
